// File: rtl/nes_poll_ctrl.sv
// NES controller poller: drives latch/pulse, samples serial data, and publishes
// per-bit strobes plus a complete active-high button frame.
module nes_poll_ctrl #(
  parameter int unsigned TICK_DIV = 300,
  parameter int unsigned POLL_DIV = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [3:0] bit_index,
  output logic       bit_data,
  output logic       bit_valid,
  output logic [7:0] buttons,
  output logic       frame_done
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);
  localparam logic [PollW-1:0] PollMax = PollW'(POLL_DIV - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StWait, StPulse, StLow} state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [PollW-1:0] poll_q;
  logic [TickW-1:0] tick_q;
  logic             half_q;   // second tick of the latch window
  logic [2:0]       pulse_q;  // pulses completed so far, 0..7
  logic [7:0]       shadow_q; // frame being assembled, active-high
  logic             data_s;
  logic             tick_end;

  assign data_s   = sync_q[1];
  assign tick_end = (tick_q == TickMax);

  // Two-flop synchronizer for the asynchronous serial data line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], nes_data};
    end
  end

  // Frame-period counter; parked at zero whenever polling is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_q <= '0;
    end else if (!enable || poll_q == PollMax) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + 1'b1;
    end
  end

  // Protocol sequencer with registered pin, strobe and frame outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      half_q     <= 1'b0;
      pulse_q    <= '0;
      shadow_q   <= '0;
      nes_latch  <= 1'b0;
      nes_pulse  <= 1'b0;
      bit_index  <= '0;
      bit_data   <= 1'b1;
      bit_valid  <= 1'b0;
      buttons    <= '0;
      frame_done <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      // Timed states wrap the tick counter at their end, so every entry starts at 0.
      if (state_q != StIdle) begin
        tick_q <= tick_end ? '0 : tick_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          tick_q <= '0;
          // A start that lands while a frame is running is simply never seen here.
          if (enable && poll_q == '0) begin
            state_q   <= StLatch;
            nes_latch <= 1'b1;
            half_q    <= 1'b0;
            pulse_q   <= '0;
          end
        end
        StLatch: begin
          if (tick_end) begin
            if (half_q) begin
              state_q   <= StWait;
              nes_latch <= 1'b0;
              half_q    <= 1'b0;
            end else begin
              half_q <= 1'b1;
            end
          end
        end
        StWait: begin
          if (tick_end) begin
            bit_index   <= 4'd1;
            bit_data    <= data_s;
            bit_valid   <= 1'b1;
            shadow_q[0] <= ~data_s;
            state_q     <= StPulse;
            nes_pulse   <= 1'b1;
          end
        end
        StPulse: begin
          if (tick_end) begin
            state_q   <= StLow;
            nes_pulse <= 1'b0;
          end
        end
        StLow: begin
          if (tick_end) begin
            if (pulse_q == 3'd7) begin
              // Eighth pulse only clocks the register out; publish the frame.
              state_q    <= StIdle;
              buttons    <= shadow_q;
              frame_done <= 1'b1;
              bit_index  <= '0;
            end else begin
              bit_index                       <= 4'(pulse_q) + 4'd2;
              bit_data                        <= data_s;
              bit_valid                       <= 1'b1;
              shadow_q[3'(pulse_q + 3'd1)]    <= ~data_s;
              pulse_q                         <= pulse_q + 3'd1;
              state_q                         <= StPulse;
              nes_pulse                       <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          nes_latch <= 1'b0;
          nes_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nes_poll_ctrl.md
Name: nes_poll_ctrl

Overview:
Drives the NES controller's latch and pulse pins and samples the serial data line. It presents each sampled bit with its 1..8 position index to the downstream button-code mux, which turns index plus active-low data into a 4-bit code. It also captures a full 8-button frame into an active-high register for the rest of the design. Polling repeats at a fixed period.

Parameters:
TICK_DIV, 300, clk cycles per protocol tick (6 us at 50 MHz); must be >= 2
POLL_DIV, 833333, clk cycles between frame starts (60 Hz at 50 MHz); must be > 19*TICK_DIV

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  polling enable
nes_data  input  1  controller serial data, asynchronous, low = pressed
nes_latch  output  1  controller latch pin
nes_pulse  output  1  controller clock pin
bit_index  output  4  current bit position 1..8; 0 when not shifting
bit_data  output  1  sampled raw serial bit (low = pressed)
bit_valid  output  1  one-cycle strobe when bit_index/bit_data update
buttons  output  8  last complete frame, active-high; [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right
frame_done  output  1  one-cycle strobe when buttons updates

Behaviour:
- Design is one clock domain. There is one asynchronous active-low reset, reset_n. All flops clear immediately on reset_n low, including mid-frame.
- Reset values: nes_latch=0, nes_pulse=0, bit_index=0, bit_data=1, bit_valid=0, buttons=8'h00, frame_done=0. FSM goes to IDLE and all counters go to 0.
- nes_data passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value.
- poll_cnt:
  - Counts 0..POLL_DIV-1 and wraps while enable=1.
  - Held at 0 while enable=0 and FSM is IDLE.
- tick_cnt: counts 0..TICK_DIV-1 within each timed state. It clears on every state entry. A state ends on the edge where tick_cnt==TICK_DIV-1.
- FSM states: IDLE, LATCH, WAIT, PULSE, LOW.
  - IDLE -> LATCH when enable=1 and poll_cnt==0.
  - LATCH lasts 2 ticks with nes_latch=1.
  - WAIT lasts 1 tick; all pins low.
  - PULSE lasts 1 tick with nes_pulse=1.
  - LOW lasts 1 tick; all pins low.
  - Sequence per frame: LATCH, WAIT, then (PULSE, LOW) x8, then IDLE.
  - Frame length is exactly 19*TICK_DIV cycles. nes_latch and nes_pulse are registered outputs decoded from the state.
- Sampling:
  - On the edge ending WAIT, bit k=1 is sampled.
  - On the edge ending the LOW of pulse k (k=1..7), bit k+1 is sampled.
  - On each sample edge: bit_index<=k, bit_data<=sync data, bit_valid<=1 for exactly one cycle, and internal shadow[k-1]<=~sync data.
  - bit_index holds k until the next sample.
- End of frame:
  - On the edge ending the 8th LOW, buttons<=shadow, frame_done<=1 for one cycle, and bit_index<=0.
  - The 8th pulse produces no sample.
- enable deasserted mid-frame: the frame completes normally, including the buttons update. The FSM then stays in IDLE.
- enable reasserted from idle: the frame starts on the next edge, since poll_cnt is 0.
- Overrun: if poll_cnt reaches 0 while not in IDLE (POLL_DIV violated), that start is skipped. The next start happens at the following poll_cnt==0.
- buttons never shows a partial frame. A reset mid-frame leaves buttons=0.

Test Plan:
- TICK_DIV=4, POLL_DIV=100, enable=1 from reset release, nes_data held 1 -> nes_latch high cycles 1-8, first sample at cycle 12, eight pulses of 4 cycles, frame_done at cycle 76, buttons=8'h00, next latch at cycle 101.
- Same params, controller model shifts A=0, Start=0, Right=0, others 1 -> bit_index steps 1..8 with 8 bit_valid strobes, bit_data=0 at indices 1, 4, 8, buttons=8'h89 at frame_done.
- Two frames with patterns 8'h89 then 8'h42 -> buttons stays 8'h89 through all of frame 2 until frame 2's frame_done, then becomes 8'h42.
- enable dropped at cycle 30 mid-frame -> frame completes, frame_done fires, no further latch. enable raised later -> latch high on the next cycle.
- reset_n pulsed low during the 3rd PULSE -> all outputs return to reset values asynchronously. After release with enable=1, a fresh frame starts with bit_index sequence 1..8.
- POLL_DIV=50 with TICK_DIV=4 (overrun) -> the start at cycle 51 is skipped, the next frame starts at cycle 101, and there is no glitch on nes_latch.
